// File: rtl/fetch_pc_control_pkg.sv
// Shared definitions for the instruction-fetch control block.
//   - redirect_sel_e : encoding of the RedirectSel input
//   - slot_state_e   : occupancy of the IF/ID pipeline slot
//   - PC_W           : program-counter width (PC is a word index)
//   - NOP_INSTR_DEFAULT : instruction word used to fill IF/ID on a bubble
package fetch_pc_control_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'b00,
        REDIR_BRANCH = 2'b01,
        REDIR_JUMP   = 2'b10,
        REDIR_JR     = 2'b11
    } redirect_sel_e;

    typedef enum logic {
        SLOT_BUBBLE = 1'b0,
        SLOT_LOADED = 1'b1
    } slot_state_e;

endpackage

// File: rtl/fetch_pc_control_next_pc_select.sv
// Combinational redirect-target mux.
//   redirect_sel_i     : redirect kind (see redirect_sel_e)
//   redirect_pc_plus1_i: PC+1 of the redirecting instruction
//   branch_imm_i       : signed word offset for branches
//   jump_index_i       : 26-bit jump target field
//   jr_target_i        : register value for jump-register
//   target_o           : redirect target PC (modulo 2^32, wrap not flagged)
module next_pc_select
    import fetch_pc_control_pkg::*;
(
    input  logic [1:0]      redirect_sel_i,
    input  logic [PC_W-1:0] redirect_pc_plus1_i,
    input  logic [15:0]     branch_imm_i,
    input  logic [25:0]     jump_index_i,
    input  logic [PC_W-1:0] jr_target_i,
    output logic [PC_W-1:0] target_o
);

    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;

    // Offsets are in words because the PC is a word index.
    assign branch_target = redirect_pc_plus1_i + {{16{branch_imm_i[15]}}, branch_imm_i};
    // Jump keeps the top 6 bits of the redirecting instruction's PC+1 region.
    assign jump_target   = {redirect_pc_plus1_i[31:26], jump_index_i};

    always_comb begin
        target_o = redirect_pc_plus1_i;
        unique case (redirect_sel_e'(redirect_sel_i))
            REDIR_BRANCH: target_o = branch_target;
            REDIR_JUMP:   target_o = jump_target;
            REDIR_JR:     target_o = jr_target_i;
            default:      target_o = redirect_pc_plus1_i;
        endcase
    end

endmodule

// File: rtl/fetch_pc_control.sv
// Instruction-fetch control: PC register, next-PC selection and IF/ID register.
//   Clk, Reset          : clock (rising edge) and async active-high reset
//   PCAddResult         : PC+1 from the external PC adder (sequential next PC)
//   Instruction         : instruction memory data for PCResult
//   Stall               : hold PC, IF/ID and counters
//   RedirectSel, RedirectPCPlus1, BranchImm, JumpIndex, JRTarget : redirect request
//   PCResult            : current PC
//   IFID_Instruction, IFID_PCPlus1, IFID_Valid : IF/ID register contents
//   FetchCount, FlushCount : saturating statistics counters
// Edge priority: Reset > redirect > Stall > sequential fetch.
// Handshake: none; Stall is a level hold request, RedirectSel != 0 is a
// one-edge command sampled on every rising edge regardless of Stall.
module fetch_pc_control
    import fetch_pc_control_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PCAddResult,
    input  logic [31:0]      Instruction,
    input  logic             Stall,
    input  logic [1:0]       RedirectSel,
    input  logic [31:0]      RedirectPCPlus1,
    input  logic [15:0]      BranchImm,
    input  logic [25:0]      JumpIndex,
    input  logic [31:0]      JRTarget,
    output logic [31:0]      PCResult,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCPlus1,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] FetchCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [PC_W-1:0]  pc_plus1_q, pc_plus1_d;
    slot_state_e      slot_q, slot_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [PC_W-1:0]  redirect_target;
    logic             redirect;

    next_pc_select u_next_pc_select (
        .redirect_sel_i      (RedirectSel),
        .redirect_pc_plus1_i (RedirectPCPlus1),
        .branch_imm_i        (BranchImm),
        .jump_index_i        (JumpIndex),
        .jr_target_i         (JRTarget),
        .target_o            (redirect_target)
    );

    assign redirect = (RedirectSel != REDIR_NONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc_plus1_q  <= '0;
            slot_q      <= SLOT_BUBBLE;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus1_q  <= pc_plus1_d;
            slot_q      <= slot_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus1_d  = pc_plus1_q;
        slot_d      = slot_q;
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (redirect) begin
            // Redirect overrides Stall: the wrong-path fetch is discarded.
            pc_d        = redirect_target;
            instr_d     = NOP_INSTR;
            pc_plus1_d  = '0;
            slot_d      = SLOT_BUBBLE;
            flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
        end else if (!Stall) begin
            pc_d        = PCAddResult;
            instr_d     = Instruction;
            pc_plus1_d  = PCAddResult;
            slot_d      = SLOT_LOADED;
            fetch_cnt_d = (fetch_cnt_q == CNT_MAX) ? fetch_cnt_q : fetch_cnt_q + CNT_W'(1);
        end
    end

    assign PCResult         = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus1     = pc_plus1_q;
    assign IFID_Valid       = (slot_q == SLOT_LOADED);
    assign FetchCount       = fetch_cnt_q;
    assign FlushCount       = flush_cnt_q;

endmodule

// File: tb/tb_fetch_pc_control.sv
module tb_fetch_pc_control;

  logic        clk;
  logic        reset;
  logic [31:0] pc_add_result;
  logic [31:0] instruction;
  logic        stall;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_pc_plus1;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc_result;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_pc_control dut (
    .Clk              (clk),
    .Reset            (reset),
    .PCAddResult      (pc_add_result),
    .Instruction      (instruction),
    .Stall            (stall),
    .RedirectSel      (redirect_sel),
    .RedirectPCPlus1  (redirect_pc_plus1),
    .BranchImm        (branch_imm),
    .JumpIndex        (jump_index),
    .JRTarget         (jr_target),
    .PCResult         (pc_result),
    .IFID_Instruction (ifid_instruction),
    .IFID_PCPlus1     (ifid_pc_plus1),
    .IFID_Valid       (ifid_valid),
    .FetchCount       (fetch_count),
    .FlushCount       (flush_count)
  );

  // Environment: PC adder and instruction memory (imem[i] = 0x1000_0000 + i).
  assign pc_add_result = pc_result + 32'd1;
  assign instruction   = 32'h1000_0000 + pc_result;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] rpc1;
    logic [15:0] bimm;
    logic [25:0] jidx;
    logic [31:0] jr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] e_pc1;
    logic        e_v;
    logic [31:0] e_fc;
    logic [31:0] e_flc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic st, input logic [1:0] sel, input logic [31:0] rpc1,
                         input logic [15:0] bimm, input logic [25:0] jidx, input logic [31:0] jr,
                         input logic [31:0] e_pc, input logic [31:0] e_ins, input logic [31:0] e_pc1,
                         input logic e_v, input logic [31:0] e_fc, input logic [31:0] e_flc);
    vec_t v;
    v.stall = st; v.sel = sel; v.rpc1 = rpc1; v.bimm = bimm; v.jidx = jidx; v.jr = jr;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_pc1 = e_pc1; v.e_v = e_v; v.e_fc = e_fc; v.e_flc = e_flc;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [31:0] e_pc1, input logic e_v, input logic [31:0] e_fc,
                           input logic [31:0] e_flc);
    check32({tag, ".pc"},    pc_result,        e_pc);
    check32({tag, ".ins"},   ifid_instruction, e_ins);
    check32({tag, ".pc1"},   ifid_pc_plus1,    e_pc1);
    check32({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_v});
    check32({tag, ".fetch"}, fetch_count,      e_fc);
    check32({tag, ".flush"}, flush_count,      e_flc);
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic [31:0] rpc1,
                       input logic [15:0] bimm, input logic [25:0] jidx, input logic [31:0] jr);
    stall = st; redirect_sel = sel; redirect_pc_plus1 = rpc1;
    branch_imm = bimm; jump_index = jidx; jr_target = jr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 16'd0, 26'd0, 32'd0);

    // Free-running fetch 0..7 -> PC reaches 8
    for (int i = 0; i < 8; i++)
      add_vec(1'b0, 2'b00, 0, 0, 0, 0,
              32'(i + 1), 32'h1000_0000 + 32'(i), 32'(i + 1), 1'b1, 32'(i + 1), 0);
    // Stall three edges at PC=8
    for (int i = 0; i < 3; i++)
      add_vec(1'b1, 2'b00, 0, 0, 0, 0, 32'd8, 32'h1000_0007, 32'd8, 1'b1, 32'd8, 0);
    // Release
    add_vec(1'b0, 2'b00, 0, 0, 0, 0, 32'd9, 32'h1000_0008, 32'd9, 1'b1, 32'd9, 0);
    // Branch backwards: 0x10 + (-4) = 0x0C
    add_vec(1'b0, 2'b01, 32'h10, 16'hFFFC, 0, 0, 32'h0C, 32'h0, 32'h0, 1'b0, 32'd9, 32'd1);
    // Fetch at 0x0C
    add_vec(1'b0, 2'b00, 0, 0, 0, 0, 32'h0D, 32'h1000_000C, 32'h0D, 1'b1, 32'd10, 32'd1);
    // Jump: {0xF000_0001[31:26], 0x123}
    add_vec(1'b0, 2'b10, 32'hF000_0001, 0, 26'h0000123, 0, 32'hF000_0123, 32'h0, 32'h0, 1'b0, 32'd10, 32'd2);
    // Jump-register to all-ones (back-to-back redirect)
    add_vec(1'b0, 2'b11, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'd10, 32'd3);
    // Sequential from 0xFFFF_FFFF wraps PC to 0
    add_vec(1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0FFF_FFFF, 32'h0, 1'b1, 32'd11, 32'd3);
    // Redirect beats stall
    add_vec(1'b1, 2'b11, 0, 0, 0, 32'h40, 32'h40, 32'h0, 32'h0, 1'b0, 32'd11, 32'd4);
    // Stall while bubble: everything holds
    add_vec(1'b1, 2'b00, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 1'b0, 32'd11, 32'd4);
    // Forward branch 0x41 + 2 = 0x43
    add_vec(1'b0, 2'b01, 32'h41, 16'h0002, 0, 0, 32'h43, 32'h0, 32'h0, 1'b0, 32'd11, 32'd5);
    // Fetch at 0x43
    add_vec(1'b0, 2'b00, 0, 0, 0, 0, 32'h44, 32'h1000_0043, 32'h44, 1'b1, 32'd12, 32'd5);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: drive at negedge, check 1 after next posedge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].sel, vecs[i].rpc1, vecs[i].bimm, vecs[i].jidx, vecs[i].jr);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_pc1,
                vecs[i].e_v, vecs[i].e_fc, vecs[i].e_flc);
      @(negedge clk);
    end

    // Asynchronous reset during a stalled redirect sequence
    drive(1'b1, 2'b11, 0, 0, 0, 32'h80);
    @(posedge clk);
    #1;
    check_all("pre_rst", 32'h80, 32'h0, 32'h0, 1'b0, 32'd12, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    // Held through an edge with a redirect still requested
    @(posedge clk);
    #1;
    check_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("post_rst", 32'h1, 32'h1000_0000, 32'h1, 1'b1, 32'd1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
